// File: rtl/bound_flasher_ctrl.sv
// rtl/bound_flasher_ctrl.sv - lamp-bar sequencer: walks the lit count between fixed bounds with flick kickback
// Drives a thermometer lamp vector from the registered lit-lamp count.
module bound_flasher_ctrl #(
  parameter int N_LAMP      = 32,
  parameter int C_HI        = 16,
  parameter int C_MID       = 11,
  parameter int C_LO        = 6,
  parameter int STEP_CYCLES = 1,
  localparam int IW = (N_LAMP > 1) ? $clog2(N_LAMP) : 1,
  localparam int CW = $clog2(N_LAMP + 1),
  localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flick,
  output logic [N_LAMP-1:0] lamp,
  output logic [CW-1:0]     cnt,
  output logic              busy,
  output logic              done
);

  if (!(C_LO > 0 && C_LO < C_MID && C_MID < C_HI && C_HI <= N_LAMP && STEP_CYCLES >= 1)) begin : g_bad_params
    $error("bound_flasher_ctrl: illegal bound parameters");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UP1  = 3'd1,
    DN1  = 3'd2,
    UP2  = 3'd3,
    DN2  = 3'd4,
    UP3  = 3'd5,
    DN3  = 3'd6
  } state_t;

  localparam logic [CW-1:0] HI   = CW'(C_HI);
  localparam logic [CW-1:0] MID  = CW'(C_MID);
  localparam logic [CW-1:0] LO   = CW'(C_LO);
  localparam logic [PW-1:0] PLST = PW'(STEP_CYCLES - 1);

  state_t        state;
  logic [PW-1:0] pre;
  logic          tick;
  logic          up;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    tick    = busy && (pre == PLST);
    up      = (state == UP1) || (state == UP2) || (state == UP3);
    cnt_nxt = up ? cnt + 1'b1 : cnt - 1'b1;
  end

  // Transitions are judged against the count this tick produces, not the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      pre   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          pre <= '0;
          cnt <= '0;
          if (flick) begin
            state <= UP1;
            busy  <= 1'b1;
          end
        end
        UP1, DN1, UP2, DN2, UP3, DN3: begin
          pre <= tick ? '0 : pre + 1'b1;
          if (tick) begin
            cnt <= cnt_nxt;
            case (state)
              UP1: if (cnt_nxt == HI) state <= DN1;
              DN1: if (cnt_nxt == LO) state <= flick ? UP1 : UP2;
              UP2: if (cnt_nxt == MID) state <= DN2;
              DN2: begin
                if (cnt_nxt == LO && flick) state <= UP2;
                else if (cnt_nxt == '0) state <= flick ? UP2 : UP3;
              end
              UP3: if (cnt_nxt == LO) state <= DN3;
              DN3: begin
                if (cnt_nxt == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          pre   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Thermometer decoder: index = cnt-1, gated off when nothing is lit.
  logic [IW-1:0] idx;
  logic          en;

  always_comb begin
    idx  = IW'(cnt - 1'b1);
    en   = (cnt != '0);
    lamp = '0;
    for (int i = 0; i < N_LAMP; i++) begin
      lamp[i] = en && (IW'(i) <= idx);
    end
  end

endmodule

// File: tb/tb_bound_flasher_ctrl.sv
// tb/tb_bound_flasher_ctrl.sv - checks two sequencer instances (1 and 4 cycles per step) against a leg-table model
module tb_bound_flasher_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flick = 1'b0;
  logic [31:0] lamp1, lamp4;
  logic [5:0]  cnt1, cnt4;
  logic        busy1, busy4, done1, done4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bound_flasher_ctrl #(.STEP_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flick(flick),
    .lamp(lamp1), .cnt(cnt1), .busy(busy1), .done(done1)
  );

  bound_flasher_ctrl #(.STEP_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flick(flick),
    .lamp(lamp4), .cnt(cnt4), .busy(busy4), .done(done4)
  );

  // Sequence as a list of legs: target count per leg, even legs climb, odd legs descend.
  int leg_target[6] = '{16, 6, 11, 0, 6, 0};
  int step_len[2] = '{1, 4};
  bit m_act[2];
  bit m_done[2];
  int m_cnt[2];
  int m_pre[2];
  int m_leg[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] therm(input int c);
    logic [32:0] t;
    t = (33'd1 << c) - 33'd1;
    return t[31:0];
  endfunction

  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_done[i] = 0; m_cnt[i] = 0; m_pre[i] = 0; m_leg[i] = 0;
    end
  endtask

  task automatic mstep(input int i, input bit f);
    bit t;
    m_done[i] = 0;
    if (!m_act[i]) begin
      if (f) begin
        m_act[i] = 1; m_pre[i] = 0; m_leg[i] = 0; m_cnt[i] = 0;
      end
    end else begin
      t = (m_pre[i] == step_len[i] - 1);
      m_pre[i] = t ? 0 : m_pre[i] + 1;
      if (t) begin
        m_cnt[i] += (m_leg[i] % 2 == 0) ? 1 : -1;
        if (m_leg[i] == 3 && m_cnt[i] == 6 && f) m_leg[i] = 2;
        else if (m_cnt[i] == leg_target[m_leg[i]]) begin
          if (m_leg[i] == 1) m_leg[i] = f ? 0 : 2;
          else if (m_leg[i] == 3) m_leg[i] = f ? 2 : 4;
          else if (m_leg[i] == 5) begin m_act[i] = 0; m_done[i] = 1; end
          else m_leg[i] = m_leg[i] + 1;
        end
      end
    end
  endtask

  task automatic cmp_all();
    chk("cnt1", 32'(cnt1), 32'(m_cnt[0]));
    chk("lamp1", lamp1, therm(m_cnt[0]));
    chk("busy1", 32'(busy1), 32'(m_act[0]));
    chk("done1", 32'(done1), 32'(m_done[0]));
    chk("cnt4", 32'(cnt4), 32'(m_cnt[1]));
    chk("lamp4", lamp4, therm(m_cnt[1]));
    chk("busy4", 32'(busy4), 32'(m_act[1]));
    chk("done4", 32'(done4), 32'(m_done[1]));
  endtask

  task automatic cyc(input bit f);
    flick = f;
    mstep(0, f);
    mstep(1, f);
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  task automatic do_reset(input bit f_hold);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    flick = f_hold;
    mreset();
    #1;
    cmp_all();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    mreset();
    @(posedge clk);
    #1;
    cmp_all();
    rst_n = 1'b1;

    // Full uninterrupted run on both instances from one flick pulse.
    for (int e = 0; e <= 230; e++) begin
      cyc(e == 0);
      if (e == 0)   chk("t2_busy_after_k", 32'(busy1), 32'd1);
      if (e == 16)  chk("t2_peak1", 32'(cnt1), 32'd16);
      if (e == 26)  chk("t2_low1", 32'(cnt1), 32'd6);
      if (e == 53)  chk("t2_nodone53", 32'(done1), 32'd0);
      if (e == 54)  begin chk("t2_done54", 32'(done1), 32'd1); chk("t2_cnt54", 32'(cnt1), 32'd0); end
      if (e == 55)  chk("t2_done55", 32'(done1), 32'd0);
      if (e == 3)   chk("t5_cnt3", 32'(cnt4), 32'd0);
      if (e == 4)   chk("t5_cnt4", 32'(cnt4), 32'd1);
      if (e == 8)   chk("t5_cnt8", 32'(cnt4), 32'd2);
      if (e == 64)  chk("t5_peak", 32'(cnt4), 32'd16);
      if (e == 215) chk("t5_nodone", 32'(done4), 32'd0);
      if (e == 216) chk("t5_done", 32'(done4), 32'd1);
    end

    // Reset in UP2 at cnt=8 takes effect without waiting for a clock edge.
    for (int e = 0; e <= 28; e++) cyc(e == 0);
    chk("t1_pre_cnt", 32'(cnt1), 32'd8);
    do_reset(1'b0);
    chk("t1_cnt", 32'(cnt1), 32'd0);
    chk("t1_lamp", lamp1, 32'd0);
    chk("t1_busy", 32'(busy1), 32'd0);
    for (int e = 0; e < 6; e++) cyc(1'b0);
    chk("t1_idle", 32'(busy1), 32'd0);

    // Kickback at the DN1 turn sends the count back up to the peak.
    for (int e = 0; e <= 36; e++) begin
      cyc(e == 0 || e == 26);
      if (e == 27) chk("t3_kick7", 32'(cnt1), 32'd7);
      if (e == 36) chk("t3_peak", 32'(cnt1), 32'd16);
    end

    // Flick held from reset release: endless UP1/DN1 loop.
    do_reset(1'b1);
    for (int e = 0; e < 300; e++) begin
      cyc(1'b1);
      if (e >= 16) chk("t6_bound", 32'(cnt1 >= 6 && cnt1 <= 16), 32'd1);
      chk("t6_nodone", 32'(done1 | done4), 32'd0);
    end

    // Random flick traffic exercising kickbacks and ignored pulses.
    for (int e = 0; e < 4000; e++) cyc($urandom_range(0, 5) == 0);
    for (int e = 0; e < 300; e++) cyc(1'b0);
    chk("drain_idle1", 32'(busy1), 32'd0);
    chk("drain_idle4", 32'(busy4), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
